// File: rtl/alu_result_stage.sv
// Two-entry result buffer behind addsub_16bit: per-entry Z/V/N flags plus the FLAGS register.
// Optional push-time result checker enabled by ALU_RESULT_STAGE_CHECK_EN.
module alu_result_stage #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      in_s,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_s,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_zvn,
  output logic [2:0]       out_upd,
  output logic [2:0]       flags,
  output logic             chk_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_t;

  cnt_t cnt_q, cnt_d;
  logic hd_q, tl_q;
  logic push, pop;

  logic [15:0]      s_q   [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [2:0]       zvn_q [DEPTH];
  logic [2:0]       upd_q [DEPTH];
  logic [2:0]       flags_q;

  logic [16:0] sum, dif;
  logic        ov_add, ov_sub;
  logic        v_in;
  logic [2:0]  upd_in, zvn_in;

  assign in_ready  = (cnt_q != FULL);
  assign out_valid = (cnt_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_s   = s_q[hd_q];
  assign out_tag = tag_q[hd_q];
  assign out_zvn = zvn_q[hd_q];
  assign out_upd = upd_q[hd_q];
  assign flags   = flags_q;

  // 17-bit sign-extended arithmetic exposes signed overflow
  assign sum    = {in_a[15], in_a} + {in_b[15], in_b};
  assign dif    = {in_a[15], in_a} - {in_b[15], in_b};
  assign ov_add = sum[16] ^ sum[15];
  assign ov_sub = dif[16] ^ dif[15];

  always_comb begin
    v_in   = 1'b0;
    upd_in = 3'b100;
    unique case (1'b1)
      (in_op == 2'b00): begin
        v_in   = ov_add;
        upd_in = 3'b111;
      end
      (in_op == 2'b01): begin
        v_in   = ov_sub;
        upd_in = 3'b111;
      end
      default: begin
        v_in   = 1'b0;
        upd_in = 3'b100;
      end
    endcase
  end

  assign zvn_in = {(in_s == 16'h0000), v_in, in_s[15]};

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_t'(cnt_q + 2'd1);
      2'b01:   cnt_d = cnt_t'(cnt_q - 2'd1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= EMPTY;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd_q    <= 1'b0;
      tl_q    <= 1'b0;
      flags_q <= 3'b000;
      for (int i = 0; i < DEPTH; i++) begin
        s_q[i]   <= '0;
        tag_q[i] <= '0;
        zvn_q[i] <= '0;
        upd_q[i] <= '0;
      end
    end else begin
      if (push) begin
        s_q[tl_q]   <= in_s;
        tag_q[tl_q] <= in_tag;
        zvn_q[tl_q] <= zvn_in;
        upd_q[tl_q] <= upd_in;
        tl_q        <= ~tl_q;
      end
      if (pop) begin
        hd_q    <= ~hd_q;
        flags_q <= (flags_q & ~out_upd) | (out_zvn & out_upd);
      end
    end
  end

`ifdef ALU_RESULT_STAGE_CHECK_EN
  logic [15:0] exp_s, padd_s;
  logic [4:0]  nsum;
  logic        chk_q, mis;

  always_comb begin
    padd_s = '0;
    nsum   = '0;
    for (int i = 0; i < 4; i++) begin
      nsum = {in_a[4*i+3], in_a[4*i +: 4]}
           + {in_b[4*i+3], in_b[4*i +: 4]};
      if (nsum[4] ^ nsum[3])
        padd_s[4*i +: 4] = nsum[4] ? 4'h8 : 4'h7;
      else
        padd_s[4*i +: 4] = nsum[3:0];
    end
  end

  always_comb begin
    exp_s = in_s;
    unique case (1'b1)
      (in_op == 2'b00):
        exp_s = ov_add ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0];
      (in_op == 2'b01):
        exp_s = ov_sub ? (dif[16] ? 16'h8000 : 16'h7fff) : dif[15:0];
      (in_op == 2'b10):
        exp_s = padd_s;
      default:
        exp_s = in_s;
    endcase
  end

  assign mis = push & (in_op != 2'b11) & (exp_s != in_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
    end else if (mis) begin
      chk_q <= 1'b1;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flags, backpressure, wrap, reset.
// Checker behaviour follows ALU_RESULT_STAGE_CHECK_EN.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a, in_b, in_s;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_s;
  logic [3:0]  out_tag;
  logic [2:0]  out_zvn, out_upd, flags;
  logic        chk_err;

  int nchk  = 0;
  int nfail = 0;

  alu_result_stage #(.TAG_W(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_s      (in_s),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_tag   (out_tag),
    .out_zvn   (out_zvn),
    .out_upd   (out_upd),
    .flags     (flags),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] s,
                       input logic [3:0] tg);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_s     = s;
    in_tag   = tg;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_s      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_s", 32'(out_s), 32'd0);
    chk("rst_out_zvn", 32'(out_zvn), 32'd0);
    chk("rst_out_upd", 32'(out_upd), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_chk_err", 32'(chk_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // add overflow
    out_ready = 1'b1;
    drive(2'b00, 16'h7000, 16'h2000, 16'h7fff, 4'h3);
    step();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_s", 32'(out_s), 32'h7fff);
    chk("add_tag", 32'(out_tag), 32'h3);
    chk("add_zvn", 32'(out_zvn), 32'b010);
    chk("add_upd", 32'(out_upd), 32'b111);
    step();
    chk("add_flags", 32'(flags), 32'b010);
    chk("add_drained", 32'(out_valid), 32'd0);

    // sub to zero
    drive(2'b01, 16'h0005, 16'h0005, 16'h0000, 4'h4);
    step();
    in_valid = 1'b0;
    chk("subz_zvn", 32'(out_zvn), 32'b100);
    step();
    chk("subz_flags", 32'(flags), 32'b100);

    // sub negative overflow
    drive(2'b01, 16'h8000, 16'h0001, 16'h8000, 4'h5);
    step();
    in_valid = 1'b0;
    chk("subv_zvn", 32'(out_zvn), 32'b011);
    step();
    chk("subv_flags", 32'(flags), 32'b011);

    // padd writes only Z
    drive(2'b10, 16'h1111, 16'h2222, 16'h3333, 4'h6);
    step();
    in_valid = 1'b0;
    chk("padd_zvn", 32'(out_zvn), 32'b000);
    chk("padd_upd", 32'(out_upd), 32'b100);
    step();
    chk("padd_flags", 32'(flags), 32'b011);

    // red with zero result sets Z, holds V/N
    drive(2'b11, 16'h0000, 16'h0000, 16'h0000, 4'h7);
    step();
    in_valid = 1'b0;
    step();
    chk("red_flags", 32'(flags), 32'b111);

    // backpressure
    out_ready = 1'b0;
    drive(2'b00, 16'h0000, 16'h0001, 16'h0001, 4'h1);
    step();
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    chk("bp_head1", 32'(out_s), 32'h0001);
    drive(2'b00, 16'h0000, 16'h0002, 16'h0002, 4'h2);
    step();
    chk("bp_rdy2", 32'(in_ready), 32'd0);
    drive(2'b00, 16'h0000, 16'h0003, 16'h0003, 4'h3);
    step();
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_head", 32'(out_s), 32'h0001);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_indep", 32'(in_ready), 32'd0);
    step();
    chk("bp_out2", 32'(out_s), 32'h0002);
    chk("bp_tag2", 32'(out_tag), 32'h2);
    chk("bp_rdy_one", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3", 32'(out_s), 32'h0003);
    chk("bp_val3", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_flags", 32'(flags), 32'b000);

    // streaming at count=1, pointers wrap
    drive(2'b00, 16'h0000, 16'h0010, 16'h0010, 4'h0);
    step();
    chk("st_first", 32'(out_s), 32'h0010);
    for (int i = 1; i <= 8; i++) begin
      drive(2'b00, 16'h0000, 16'(16'h0010 + i),
            16'(16'h0010 + i), 4'(i));
      step();
      chk("st_s", 32'(out_s), 32'(16'h0010 + i));
      chk("st_tag", 32'(out_tag), 32'(i));
      chk("st_rdy", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("st_empty", 32'(out_valid), 32'd0);

    // negative result sets N, then fill and reset mid-stream
    drive(2'b00, 16'h0000, 16'hffff, 16'hffff, 4'h9);
    step();
    in_valid = 1'b0;
    step();
    chk("neg_flags", 32'(flags), 32'b001);
    out_ready = 1'b0;
    drive(2'b00, 16'h0000, 16'h0004, 16'h0004, 4'ha);
    step();
    step();
    in_valid = 1'b0;
    chk("full_rdy", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    chk("mrst_flags", 32'(flags), 32'd0);
    chk("mrst_s", 32'(out_s), 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("mrst_stay", 32'(out_valid), 32'd0);

    // result checker
    out_ready = 1'b1;
    drive(2'b00, 16'h0001, 16'h0001, 16'h0003, 4'h1);
    step();
    in_valid = 1'b0;
    step();
    step();
`ifdef ALU_RESULT_STAGE_CHECK_EN
    chk("chk_set", 32'(chk_err), 32'd1);
    drive(2'b00, 16'h0001, 16'h0001, 16'h0002, 4'h2);
    step();
    in_valid = 1'b0;
    step();
    chk("chk_sticky", 32'(chk_err), 32'd1);
`else
    chk("chk_tied", 32'(chk_err), 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    chk("chk_clr", 32'(chk_err), 32'd0);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
